aes_host_link: RTL
==================

AES_HOST_LINK -- requirements
Module: aes_host_link

Interface
REQ-001 Parameter PULSE_CYCLES, default 1100: cycles each strobe is held high; SHALL exceed the target debounce limit.
REQ-002 Parameter GAP_CYCLES, default 1100: cycles each strobe is held low after a pulse.
REQ-003 Parameter WAIT_CYCLES, default 128: idle cycles between the last load strobe and the first read strobe.
REQ-004 clk  input  1  sole clock; all state on its rising edge.
REQ-005 rst  input  1  reset; asynchronous and active-high.
REQ-006 start  input  1  one-cycle request to run one encryption transaction.
REQ-007 pt  input  128  plaintext; sampled when start is accepted.
REQ-008 key  input  128  cipher key; sampled when start is accepted.
REQ-009 busy  output  1  high from start acceptance until done.
REQ-010 done  output  1  one-cycle pulse; ct is valid from this cycle onward.
REQ-011 ct  output  128  assembled ciphertext.
REQ-012 tx_data  output  8  plaintext byte to the target.
REQ-013 tx_key  output  8  key byte to the target.
REQ-014 sig_in  output  1  load strobe to the target.
REQ-015 sig_out  output  1  read strobe to the target.
REQ-016 rx_data  input  16  ciphertext word from the target.

Function
REQ-017 The FSM SHALL have states IDLE, TX_HI, TX_LO, WAIT, RX_HI, RX_LO and DONE.
REQ-018 In IDLE, start=1 SHALL latch pt and key into shadow registers, clear the byte/word indices, set busy and enter TX_HI on the next cycle.
REQ-019 start SHALL be ignored in every state except IDLE.
REQ-020 Byte order SHALL be MSB first: byte index n (0..15) drives tx_data=pt[127-8n -: 8] and tx_key=key[127-8n -: 8].
REQ-021 tx_data/tx_key SHALL be stable throughout TX_HI and TX_LO of the same byte.
REQ-022 TX_HI SHALL drive sig_in=1 for exactly PULSE_CYCLES cycles; TX_LO SHALL then drive sig_in=0 for exactly GAP_CYCLES cycles.
REQ-023 After TX_LO, the FSM SHALL go to TX_HI with index+1 if index<15, otherwise to WAIT.
REQ-024 WAIT SHALL last exactly WAIT_CYCLES cycles, with sig_in=sig_out=0.
REQ-025 RX_HI SHALL drive sig_out=1 for PULSE_CYCLES cycles; RX_LO SHALL drive sig_out=0 for GAP_CYCLES cycles.
REQ-026 On the last cycle of RX_LO for word index w (0..7), rx_data SHALL be captured into ct[127-16w -: 16].
REQ-027 After RX_LO, the FSM SHALL go to RX_HI with w+1 if w<7, otherwise to DONE.
REQ-028 DONE SHALL last one cycle, assert done and clear busy at the next edge, then return to IDLE.
REQ-029 ct SHALL hold its value until the next transaction's first capture; earlier words of ct SHALL NOT be cleared at start.
REQ-030 A single 16-bit down-timer SHALL be shared by all timed states.
REQ-031 The timer SHALL be reloaded on every state entry.
REQ-032 Total latency SHALL be 24*(PULSE_CYCLES+GAP_CYCLES)+WAIT_CYCLES+2 cycles from the start edge to done.
REQ-033 sig_in and sig_out SHALL never be high in the same cycle.

Reset
REQ-034 rst=1 SHALL force IDLE immediately, regardless of state.
REQ-035 rst=1 SHALL zero the indices, timer, shadow registers, ct, tx_data, tx_key, sig_in, sig_out, busy and done.
REQ-036 A reset mid-transaction SHALL abort it with no done pulse.
REQ-037 After rst is released, start SHALL be accepted on the first clock edge.

Configuration
REQ-038 Macro AES_HOST_LINK_RXSYNC_EN defined: rx_data SHALL pass through a two-flop synchronizer, and capture SHALL use the synchronized value; latency is unchanged.
REQ-039 AES_HOST_LINK_RXSYNC_EN undefined: rx_data SHALL be captured directly.

Verification (PULSE_CYCLES=4, GAP_CYCLES=4, WAIT_CYCLES=8 unless noted)
REQ-040 Start with pt=00112233445566778899aabbccddeeff and key=000102030405060708090a0b0c0d0e0f -> 16 sig_in pulses of 4 cycles each; first bytes tx_data=00, tx_key=00; last bytes ff and 0f.
REQ-041 Target model returns words 69c4, e0d8, 6a7b, 0430, d8cd, b780, 70b4, c55a -> ct=69c4e0d86a7b0430d8cdb78070b4c55a; done occurs 202 cycles after start.
REQ-042 Start pulsed again at cycles 10 and 100 of a transaction -> ignored; exactly one done; busy stays high.
REQ-043 rst asserted during byte 7 TX_HI -> sig_in=0 and busy=0 in the same cycle, no done; a fresh start afterwards completes normally.
REQ-044 Every cycle of every test -> sig_in and sig_out never both high.
REQ-045 With AES_HOST_LINK_RXSYNC_EN defined, rerun the REQ-041 scenario -> identical ct and identical latency.

Source files
------------

// File: rtl/aes_host_link.sv
// aes_host_link: bit-banged host side of an AES target link.
//
// A start request latches a 128-bit plaintext and key. The block then sends
// both MSB-first, one byte per load strobe (sig_in), waits a fixed idle gap,
// and reads eight 16-bit ciphertext words on read strobes (sig_out). Each
// strobe is held high and then low for fixed cycle counts, so a slow or
// debounced target can follow it.
//
// Parameters
//   PULSE_CYCLES : cycles each strobe is held high (must exceed target debounce)
//   GAP_CYCLES   : cycles each strobe is held low after a pulse
//   WAIT_CYCLES  : idle cycles between the last load strobe and first read strobe
//
// Ports
//   clk      in   sole clock, rising edge
//   rst      in   asynchronous active-high reset
//   start    in   one-cycle transaction request, honoured only when idle
//   pt       in   [127:0] plaintext, sampled on accepted start
//   key      in   [127:0] key, sampled on accepted start
//   busy     out  high from start acceptance until done
//   done     out  one-cycle completion pulse; ct valid from this cycle on
//   ct       out  [127:0] assembled ciphertext
//   tx_data  out  [7:0] plaintext byte to target
//   tx_key   out  [7:0] key byte to target
//   sig_in   out  load strobe
//   sig_out  out  read strobe
//   rx_data  in   [15:0] ciphertext word from target
//
// Build option
//   AES_HOST_LINK_RXSYNC_EN : when defined, rx_data passes through a two-flop
//   synchronizer before capture. Latency is unchanged because rx_data is
//   sampled only at the end of each read gap.

module aes_host_link #(
  parameter int unsigned PULSE_CYCLES = 1100,
  parameter int unsigned GAP_CYCLES   = 1100,
  parameter int unsigned WAIT_CYCLES  = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] pt,
  input  logic [127:0] key,
  output logic         busy,
  output logic         done,
  output logic [127:0] ct,
  output logic [7:0]   tx_data,
  output logic [7:0]   tx_key,
  output logic         sig_in,
  output logic         sig_out,
  input  logic [15:0]  rx_data
);

  // Timer counts down to zero, so a state lasting N cycles loads N-1.
  localparam logic [15:0] PulseLoad = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] GapLoad   = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] WaitLoad  = 16'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TX_HI = 3'd1,
    TX_LO = 3'd2,
    WAIT  = 3'd3,
    RX_HI = 3'd4,
    RX_LO = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t        state;
  logic [3:0]    byte_idx;
  logic [2:0]    word_idx;
  logic [15:0]   timer;
  logic [127:0]  pt_q;
  logic [127:0]  key_q;
  logic [3:0]    byte_nxt;
  logic [2:0]    word_nxt;
  logic [15:0]   rx_cap;

  assign byte_nxt = byte_idx + 4'd1;
  assign word_nxt = word_idx + 3'd1;

`ifdef AES_HOST_LINK_RXSYNC_EN
  logic [15:0] rx_meta;
  logic [15:0] rx_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= '0;
      rx_sync <= '0;
    end else begin
      rx_meta <= rx_data;
      rx_sync <= rx_meta;
    end
  end

  assign rx_cap = rx_sync;
`else
  assign rx_cap = rx_data;
`endif

  // Byte n sits at bit 127-8n = {~n, 3'b111}; word w at 127-16w = {~w, 4'hf}.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      byte_idx <= '0;
      word_idx <= '0;
      timer    <= '0;
      pt_q     <= '0;
      key_q    <= '0;
      ct       <= '0;
      tx_data  <= '0;
      tx_key   <= '0;
      sig_in   <= 1'b0;
      sig_out  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            pt_q     <= pt;
            key_q    <= key;
            byte_idx <= '0;
            word_idx <= '0;
            busy     <= 1'b1;
            tx_data  <= pt[127:120];
            tx_key   <= key[127:120];
            sig_in   <= 1'b1;
            timer    <= PulseLoad;
            state    <= TX_HI;
          end
        end

        TX_HI: begin
          if (timer == '0) begin
            sig_in <= 1'b0;
            timer  <= GapLoad;
            state  <= TX_LO;
          end else begin
            timer <= timer - 16'd1;
          end
        end

        TX_LO: begin
          if (timer == '0) begin
            if (byte_idx == 4'd15) begin
              timer <= WaitLoad;
              state <= WAIT;
            end else begin
              byte_idx <= byte_nxt;
              tx_data  <= pt_q[{~byte_nxt, 3'b111} -: 8];
              tx_key   <= key_q[{~byte_nxt, 3'b111} -: 8];
              sig_in   <= 1'b1;
              timer    <= PulseLoad;
              state    <= TX_HI;
            end
          end else begin
            timer <= timer - 16'd1;
          end
        end

        WAIT: begin
          if (timer == '0) begin
            sig_out <= 1'b1;
            timer   <= PulseLoad;
            state   <= RX_HI;
          end else begin
            timer <= timer - 16'd1;
          end
        end

        RX_HI: begin
          if (timer == '0) begin
            sig_out <= 1'b0;
            timer   <= GapLoad;
            state   <= RX_LO;
          end else begin
            timer <= timer - 16'd1;
          end
        end

        RX_LO: begin
          if (timer == '0) begin
            ct[{~word_idx, 4'hf} -: 16] <= rx_cap;
            if (word_idx == 3'd7) begin
              timer <= '0;
              state <= DONE;
            end else begin
              word_idx <= word_nxt;
              sig_out  <= 1'b1;
              timer    <= PulseLoad;
              state    <= RX_HI;
            end
          end else begin
            timer <= timer - 16'd1;
          end
        end

        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          sig_in  <= 1'b0;
          sig_out <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
